// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Package     : video_pkg
// Description : Shared video timing constants, pixel/word widths and the
//               line-fetch FSM state type for the pixel fetch datapath.
// Contents    : H_ACTIVE, V_ACTIVE, LINE, SCREEN  - 640x480 timing constants
//               PW, AW                            - pixel width, word address
//               fetch_state_e                     - IDLE / REQ / BURST
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int H_ACTIVE = 640;   // active pixels per line
    localparam int V_ACTIVE = 480;   // active lines per frame
    localparam int LINE     = 799;   // last sx value of a line
    localparam int SCREEN   = 524;   // last sy value of a frame
    localparam int PW       = 24;    // pixel width
    localparam int AW       = 19;    // memory word address width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/line_buf.sv
`default_nettype none
// ============================================================================
// Module      : line_buf
// Description : Two-bank line buffer built as one simple dual-port RAM.
//               Bank b occupies words [b*DEPTH, b*DEPTH+DEPTH-1].
// Ports       : clk_pix               - pixel clock
//               wr_en/wr_bank/wr_idx/wr_data - fetch write port
//               rd_en/rd_bank/rd_idx  - display read request
//               rd_data               - registered read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf
    import video_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int DW    = 24
) (
    input  logic          clk_pix,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [9:0]    wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [9:0]    rd_idx,
    output logic [DW-1:0] rd_data
);

    localparam int ABITS = $clog2(2 * DEPTH);

    logic [DW-1:0]    mem_q [2*DEPTH];
    logic [DW-1:0]    rd_data_q;
    logic [ABITS-1:0] wr_addr;
    logic [ABITS-1:0] rd_addr;

    assign wr_addr = wr_bank ? (ABITS'(wr_idx) + ABITS'(DEPTH)) : ABITS'(wr_idx);
    assign rd_addr = rd_bank ? (ABITS'(rd_idx) + ABITS'(DEPTH)) : ABITS'(rd_idx);

    // Storage carries no reset; contents are undefined until written.
    always_ff @(posedge clk_pix) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/pix_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pix_fetch_ctrl
// Description : Fetches the next display line from memory into a ping-pong
//               line buffer while the current line is scanned out. A fetch
//               still in flight at the last sx of a line is abandoned and
//               flagged with an underrun pulse; the stale bank is shown.
// Ports       : clk_pix, rst_pix (async, active-high)
//               sx, sy, de        - timing generator position / data enable
//               mem_req_*         - line read request (valid/ready)
//               mem_rd_valid/data - read data beats, no backpressure
//               pix_rgb, pix_de   - display pixel, one cycle after sx/sy/de
//               underrun          - one-cycle pulse on a missed deadline
//               underrun_cnt      - saturating 16-bit underrun count, present
//                                   only when PIX_FETCH_UNDERRUN_CNT_EN is
//                                   defined
// Revision    : 1.0 - initial release
// ============================================================================
module pix_fetch_ctrl
    import video_pkg::*;
#(
    parameter int H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE,
    parameter int LINE     = video_pkg::LINE,
    parameter int SCREEN   = video_pkg::SCREEN,
    parameter int PW       = video_pkg::PW,
    parameter int AW       = video_pkg::AW
) (
    input  logic          clk_pix,
    input  logic          rst_pix,
    input  logic [9:0]    sx,
    input  logic [9:0]    sy,
    input  logic          de,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    output logic [9:0]    mem_req_len,
    input  logic          mem_rd_valid,
    input  logic [PW-1:0] mem_rd_data,
    output logic [PW-1:0] pix_rgb,
    output logic          pix_de,
    output logic          underrun
`ifdef PIX_FETCH_UNDERRUN_CNT_EN
    ,
    output logic [15:0]   underrun_cnt
`endif
);

    fetch_state_e  state_q, state_d;
    logic [9:0]    beat_q, beat_d;
    logic          bank_q, bank_d;      // bank being filled (line[0])
    logic [AW-1:0] addr_q, addr_d;
    logic          pix_de_q;

    logic [9:0]    nxt;
    logic          trigger;
    logic          deadline;
    logic          wr_en;
    logic [PW-1:0] rd_data;

    assign nxt      = (sy == 10'(SCREEN)) ? 10'd0 : sy + 10'd1;
    assign trigger  = (sx == 10'd0) && (nxt < 10'(V_ACTIVE));
    assign deadline = (sx == 10'(LINE)) && (state_q != ST_IDLE);
    assign wr_en    = (state_q == ST_BURST) && mem_rd_valid;

    // The deadline abort outranks everything else, including a handshake or
    // the final beat landing on the same cycle.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        if (deadline) begin
            state_d = ST_IDLE;
            beat_d  = 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_d = ST_REQ;
                        bank_d  = nxt[0];
                        addr_d  = AW'(nxt) * AW'(H_ACTIVE);
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state_d = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (mem_rd_valid) begin
                        if (beat_q == 10'(H_ACTIVE - 1)) begin
                            state_d = ST_IDLE;
                            beat_d  = 10'd0;
                        end else begin
                            beat_d  = beat_q + 10'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    beat_d  = 10'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q  <= ST_IDLE;
            beat_q   <= 10'd0;
            bank_q   <= 1'b0;
            addr_q   <= '0;
            pix_de_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            pix_de_q <= de;
        end
    end

    line_buf #(
        .DEPTH (H_ACTIVE),
        .DW    (PW)
    ) u_line_buf (
        .clk_pix (clk_pix),
        .wr_en   (wr_en),
        .wr_bank (bank_q),
        .wr_idx  (beat_q),
        .wr_data (mem_rd_data),
        .rd_en   (de),
        .rd_bank (sy[0]),
        .rd_idx  (sx),
        .rd_data (rd_data)
    );

    // The RAM read register has no reset; gating with the reset pix_de flop
    // gives a clean zero at reset and during blanking.
    assign pix_rgb       = pix_de_q ? rd_data : '0;
    assign pix_de        = pix_de_q;
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_len   = 10'(H_ACTIVE);
    assign underrun      = deadline;

`ifdef PIX_FETCH_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (deadline && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            ucnt_q <= 16'd0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pix_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pix_fetch_ctrl
// Description : Self-checking bench for pix_fetch_ctrl. Drives whole lines of
//               sx (0..799) at chosen sy values, acts as the memory, and keeps
//               a per-bank picture of what each buffer word must hold.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pix_fetch_ctrl;

    localparam int HA = 640;
    localparam int VA = 480;
    localparam int LN = 799;
    localparam int SC = 524;

    logic        clk_pix = 1'b0;
    logic        rst_pix;
    logic [9:0]  sx, sy;
    logic        de;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [18:0] mem_req_addr;
    logic [9:0]  mem_req_len;
    logic        mem_rd_valid;
    logic [23:0] mem_rd_data;
    logic [23:0] pix_rgb;
    logic        pix_de;
    logic        underrun;
`ifdef PIX_FETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    pix_fetch_ctrl dut (
        .clk_pix       (clk_pix),
        .rst_pix       (rst_pix),
        .sx            (sx),
        .sy            (sy),
        .de            (de),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_len   (mem_req_len),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .pix_rgb       (pix_rgb),
        .pix_de        (pix_de),
        .underrun      (underrun)
`ifdef PIX_FETCH_UNDERRUN_CNT_EN
        ,
        .underrun_cnt  (underrun_cnt)
`endif
    );

    always #5 clk_pix = ~clk_pix;

    int errors = 0;
    int checks = 0;

    // Reference picture of the two buffer banks.
    logic [23:0] exp_bank [2][HA];
    bit          known    [2][HA];
    int          ucnt_model = 0;
    bit          prev_de    = 1'b0;
    bit          prev_known = 1'b0;
    logic [23:0] prev_rgb   = '0;

    typedef struct {
        int y;        // sy held for the whole line
        int d;        // first sx at which mem_req_ready is high
        int p;        // percent chance of a beat per burst cycle
        int key;      // data = word address ^ key
        int rst_at;   // assert reset when this many beats delivered (-1 none)
        bit exp_req;  // mem_req_valid seen at sx = 1
        int exp_addr; // mem_req_addr at sx = 1
        bit exp_ur;   // underrun seen at sx = 799
        int chk_sx;   // pixel to spot-check (-1 none)
        int chk_val;
    } line_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_valid"}, 32'(mem_req_valid), 0);
        chk({tag, "_req_addr"},  32'(mem_req_addr), 0);
        chk({tag, "_req_len"},   32'(mem_req_len), HA);
        chk({tag, "_pix_rgb"},   32'(pix_rgb), 0);
        chk({tag, "_pix_de"},    32'(pix_de), 0);
        chk({tag, "_underrun"},  32'(underrun), 0);
    endtask

    // One full line; every cycle is checked against the reference picture.
    task automatic run_line(input line_t t, output bit got_req, output int got_addr,
                            output bit got_ur, output int got_pix);
        int n;
        bit fetch;
        bit hs;
        bit aborted;
        int beats;
        n        = (t.y == SC) ? 0 : t.y + 1;
        fetch    = (n < VA);
        hs       = 1'b0;
        aborted  = 1'b0;
        beats    = 0;
        got_req  = 1'b0;
        got_addr = 0;
        got_ur   = 1'b0;
        got_pix  = 0;
        for (int x = 0; x <= LN; x++) begin
            bit burst, do_rst, dlv, rdy, req_v, exp_ur;
            logic [23:0] data;
            burst  = fetch && hs && !aborted && (beats < HA);
            do_rst = (t.rst_at >= 0) && burst && (beats == t.rst_at);
            @(posedge clk_pix);
            #1;
            rst_pix = do_rst;
            sx = 10'(x);
            sy = 10'(t.y);
            de = (t.y < VA) && (x < HA);
            rdy = (x >= t.d);
            mem_req_ready = rdy;
            dlv  = burst && !do_rst && ($urandom_range(0, 99) < t.p);
            data = 24'((n * HA + beats) ^ t.key);
            if (dlv) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = data;
            end else if (!burst && !do_rst) begin
                mem_rd_valid = ($urandom_range(0, 7) == 0);
                mem_rd_data  = 24'($urandom);
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_data  = '0;
            end
            if (do_rst) begin
                aborted    = 1'b1;
                ucnt_model = 0;
            end
            req_v  = fetch && (x >= 1) && !hs && !aborted;
            exp_ur = fetch && (x == LN) && !aborted && !(hs && beats == HA);
            @(negedge clk_pix);
            if (do_rst) begin
                check_reset_vals("mid_reset");
            end else begin
                chk("req_valid", 32'(mem_req_valid), 32'(req_v));
                if (req_v) chk("req_addr", 32'(mem_req_addr), 32'(n * HA));
                chk("req_len", 32'(mem_req_len), HA);
                chk("underrun", 32'(underrun), 32'(exp_ur));
                chk("pix_de", 32'(pix_de), 32'(prev_de));
                if (!prev_de) chk("pix_rgb_blank", 32'(pix_rgb), 0);
                else if (prev_known) chk("pix_rgb", 32'(pix_rgb), 32'(prev_rgb));
            end
            if (x == 1) begin
                got_req  = mem_req_valid;
                got_addr = int'(mem_req_addr);
            end
            if (x == LN) got_ur = underrun;
            if (x == t.chk_sx + 1) got_pix = int'(pix_rgb);
            prev_de = de && !do_rst;
            if (de) begin
                prev_rgb   = exp_bank[t.y % 2][x];
                prev_known = known[t.y % 2][x];
            end
            if (dlv) begin
                exp_bank[n % 2][beats] = data;
                known[n % 2][beats]    = 1'b1;
                beats++;
            end
            if (req_v && rdy && x != LN) hs = 1'b1;
            if (exp_ur) ucnt_model++;
        end
    endtask

    line_t tbl [15];

    initial begin
        bit g_req, g_ur;
        int g_addr, g_pix;
        line_t r;

        tbl[0]  = '{0,   0,   100, 0,     -1,  1, 640,   0, -1,  0};
        tbl[1]  = '{1,   0,   100, 0,     -1,  1, 1280,  0, 5,   645};
        tbl[2]  = '{9,   0,   100, 0,     -1,  1, 6400,  0, -1,  0};
        tbl[3]  = '{10,  700, 100, 0,     -1,  1, 7040,  1, -1,  0};
        tbl[4]  = '{11,  0,   100, 0,     -1,  1, 7680,  0, 200, 840};
        tbl[5]  = '{479, 0,   100, 0,     -1,  0, 0,     0, -1,  0};
        tbl[6]  = '{480, 0,   100, 0,     -1,  0, 0,     0, -1,  0};
        tbl[7]  = '{523, 0,   100, 0,     -1,  0, 0,     0, -1,  0};
        tbl[8]  = '{524, 0,   100, 0,     -1,  1, 0,     0, -1,  0};
        tbl[9]  = '{7,   0,   100, 'h55,  300, 1, 5120,  0, -1,  0};
        tbl[10] = '{7,   3,   100, 'hAA5, -1,  1, 5120,  0, -1,  0};
        tbl[11] = '{8,   0,   100, 0,     -1,  1, 5760,  0, 0,   7845};
        tbl[12] = '{20,  799, 100, 0,     -1,  1, 13440, 1, -1,  0};
        tbl[13] = '{21,  799, 100, 0,     -1,  1, 14080, 1, -1,  0};
        tbl[14] = '{22,  799, 100, 0,     -1,  1, 14720, 1, -1,  0};

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < HA; i++) begin
                known[b][i]    = 1'b0;
                exp_bank[b][i] = '0;
            end

        rst_pix       = 1'b1;
        sx            = 10'd100;
        sy            = 10'd0;
        de            = 1'b0;
        mem_req_ready = 1'b0;
        mem_rd_valid  = 1'b0;
        mem_rd_data   = '0;
        repeat (3) @(posedge clk_pix);
        @(negedge clk_pix);
        check_reset_vals("reset");
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;

        for (int k = 0; k < 15; k++) begin
            run_line(tbl[k], g_req, g_addr, g_ur, g_pix);
            chk($sformatf("tbl%0d_req", k), 32'(g_req), 32'(tbl[k].exp_req));
            if (tbl[k].exp_req) chk($sformatf("tbl%0d_addr", k), 32'(g_addr), 32'(tbl[k].exp_addr));
            chk($sformatf("tbl%0d_underrun", k), 32'(g_ur), 32'(tbl[k].exp_ur));
            if (tbl[k].chk_sx >= 0) chk($sformatf("tbl%0d_pix", k), 32'(g_pix), 32'(tbl[k].chk_val));
        end

`ifdef PIX_FETCH_UNDERRUN_CNT_EN
        chk("underrun_cnt_3", 32'(underrun_cnt), 3);
`endif

        for (int k = 0; k < 8; k++) begin
            r.y       = int'($urandom_range(0, SC));
            r.d       = int'($urandom_range(0, 250));
            r.p       = int'($urandom_range(60, 100));
            r.key     = int'($urandom_range(0, 4095));
            r.rst_at  = -1;
            r.exp_req = 1'b0;
            r.exp_addr = 0;
            r.exp_ur  = 1'b0;
            r.chk_sx  = -1;
            r.chk_val = 0;
            run_line(r, g_req, g_addr, g_ur, g_pix);
        end

`ifdef PIX_FETCH_UNDERRUN_CNT_EN
        chk("underrun_cnt_model", 32'(underrun_cnt), 32'(ucnt_model));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
